// File: rtl/ov7670_pixel_capture.sv
`default_nettype none
// ============================================================================
// Module      : ov7670_pixel_capture
// Description : Oversampling capture front end for the OV7670 parallel bus.
//               Synchronises PCLK/HREF/VSYNC/DATA into the system clock,
//               pairs RGB565 bytes into 16-bit pixels, emits X/Y coordinates
//               with a one-cycle valid strobe, and reports frame boundaries
//               and line-length errors.
// Revision    : 1.0 - initial release
// ============================================================================
module ov7670_pixel_capture #(
    parameter int H_ACTIVE    = 640,
    parameter int V_ACTIVE    = 480,
    parameter int SYNC_STAGES = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        pclk_in,
    input  logic        href_in,
    input  logic        vsync_in,
    input  logic [7:0]  data_in,
    input  logic        enable,
    output logic [9:0]  outX,
    output logic [8:0]  outY,
    output logic [15:0] pixelValue,
    output logic        pixelValid,
    output logic        frameStart,
    output logic        frameDone,
    output logic        lineErr,
    output logic [7:0]  frameCount
);

    // ------------------------------------------------------------------
    // Width-matched constants derived from the geometry parameters
    // ------------------------------------------------------------------
    localparam logic [9:0]  c_H_LIMIT   = 10'(H_ACTIVE);
    localparam logic [8:0]  c_V_LIMIT   = 9'(V_ACTIVE);
    localparam logic [10:0] c_H_COUNT   = 11'(H_ACTIVE);
    localparam logic [10:0] c_COUNT_MAX = 11'h7FF;

    typedef enum logic [1:0] {
        S_IDLE       = 2'd0,
        S_WAIT_FRAME = 2'd1,
        S_ACTIVE     = 2'd2
    } state_t;

    // ------------------------------------------------------------------
    // Synchroniser chains; data travels through the same depth as pclk
    // so the byte seen at a detected pclk edge is the byte that was on
    // the bus when the camera raised pclk.
    // ------------------------------------------------------------------
    logic [SYNC_STAGES-1:0] r_pclk_sync;
    logic [SYNC_STAGES-1:0] r_href_sync;
    logic [SYNC_STAGES-1:0] r_vsync_sync;
    logic [7:0]             r_data_sync [SYNC_STAGES];

    logic r_pclk_prev;
    logic r_href_prev;
    logic r_vsync_prev;

    logic       w_pclk;
    logic       w_href;
    logic       w_vsync;
    logic [7:0] w_data;

    logic w_pclk_rise;
    logic w_href_fall;
    logic w_vsync_rise;
    logic w_vsync_fall;

    // Shift camera signals through the synchroniser flops
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_pclk_sync  <= '0;
            r_href_sync  <= '0;
            r_vsync_sync <= '0;
            for (int i = 0; i < SYNC_STAGES; i++) begin
                r_data_sync[i] <= 8'd0;
            end
        end else begin
            r_pclk_sync  <= {r_pclk_sync[SYNC_STAGES-2:0], pclk_in};
            r_href_sync  <= {r_href_sync[SYNC_STAGES-2:0], href_in};
            r_vsync_sync <= {r_vsync_sync[SYNC_STAGES-2:0], vsync_in};
            r_data_sync[0] <= data_in;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                r_data_sync[i] <= r_data_sync[i-1];
            end
        end
    end

    assign w_pclk  = r_pclk_sync[SYNC_STAGES-1];
    assign w_href  = r_href_sync[SYNC_STAGES-1];
    assign w_vsync = r_vsync_sync[SYNC_STAGES-1];
    assign w_data  = r_data_sync[SYNC_STAGES-1];

    // Remember the previous synchronised levels for edge detection
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_pclk_prev  <= 1'b0;
            r_href_prev  <= 1'b0;
            r_vsync_prev <= 1'b0;
        end else begin
            r_pclk_prev  <= w_pclk;
            r_href_prev  <= w_href;
            r_vsync_prev <= w_vsync;
        end
    end

    assign w_pclk_rise  = w_pclk & ~r_pclk_prev;
    assign w_href_fall  = ~w_href & r_href_prev;
    assign w_vsync_rise = w_vsync & ~r_vsync_prev;
    assign w_vsync_fall = ~w_vsync & r_vsync_prev;

    // ------------------------------------------------------------------
    // Capture state and datapath registers
    // ------------------------------------------------------------------
    state_t      r_state;
    state_t      w_state_nxt;

    logic [9:0]  r_x;
    logic [8:0]  r_y;
    logic        r_phase;
    logic [7:0]  r_hi;
    logic [10:0] r_pix_cnt;
    logic        r_frame_started;

    logic [9:0]  w_x_nxt;
    logic [8:0]  w_y_nxt;
    logic        w_phase_nxt;
    logic [7:0]  w_hi_nxt;
    logic [10:0] w_pix_cnt_nxt;
    logic        w_frame_started_nxt;

    logic [9:0]  w_out_x_nxt;
    logic [8:0]  w_out_y_nxt;
    logic [15:0] w_pixel_value_nxt;
    logic        w_pixel_valid_nxt;
    logic        w_frame_start_nxt;
    logic        w_frame_done_nxt;
    logic        w_line_err_nxt;
    logic [7:0]  w_frame_count_nxt;

    // State register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state and next-datapath logic; line handling is evaluated
    // before frame end so a coincident hrefFall/vsyncRise does both.
    always_comb begin
        w_state_nxt         = r_state;
        w_x_nxt             = r_x;
        w_y_nxt             = r_y;
        w_phase_nxt         = r_phase;
        w_hi_nxt            = r_hi;
        w_pix_cnt_nxt       = r_pix_cnt;
        w_frame_started_nxt = r_frame_started;
        w_out_x_nxt         = outX;
        w_out_y_nxt         = outY;
        w_pixel_value_nxt   = pixelValue;
        w_pixel_valid_nxt   = 1'b0;
        w_frame_start_nxt   = 1'b0;
        w_frame_done_nxt    = 1'b0;
        w_line_err_nxt      = 1'b0;
        w_frame_count_nxt   = frameCount;

        case (r_state)
            S_IDLE: begin
                if (w_vsync_rise && enable) begin
                    w_state_nxt = S_WAIT_FRAME;
                end
            end

            S_WAIT_FRAME: begin
                if (w_vsync_fall) begin
                    w_state_nxt         = S_ACTIVE;
                    w_x_nxt             = 10'd0;
                    w_y_nxt             = 9'd0;
                    w_phase_nxt         = 1'b0;
                    w_pix_cnt_nxt       = 11'd0;
                    w_frame_started_nxt = 1'b0;
                end
            end

            S_ACTIVE: begin
                // Byte arrival: first byte is held, second completes a pixel
                if (w_pclk_rise && w_href) begin
                    if (!r_frame_started) begin
                        w_frame_start_nxt   = 1'b1;
                        w_frame_started_nxt = 1'b1;
                    end
                    if (!r_phase) begin
                        w_hi_nxt    = w_data;
                        w_phase_nxt = 1'b1;
                    end else begin
                        w_phase_nxt = 1'b0;
                        if (r_pix_cnt != c_COUNT_MAX) begin
                            w_pix_cnt_nxt = r_pix_cnt + 11'd1;
                        end
                        if ((r_x < c_H_LIMIT) && (r_y < c_V_LIMIT)) begin
                            w_pixel_valid_nxt = 1'b1;
                            w_out_x_nxt       = r_x;
                            w_out_y_nxt       = r_y;
                            w_pixel_value_nxt = {r_hi, w_data};
                        end
                        if (r_x < c_H_LIMIT) begin
                            w_x_nxt = r_x + 10'd1;
                        end
                    end
                end

                // End of line: the presented-pixel count, not the
                // saturated column, decides whether the line was short
                // or long; a dangling half pixel is also an error.
                if (w_href_fall) begin
                    if ((r_pix_cnt != c_H_COUNT) || r_phase) begin
                        w_line_err_nxt = 1'b1;
                    end
                    if (r_y < c_V_LIMIT) begin
                        w_y_nxt = r_y + 9'd1;
                    end
                    w_x_nxt       = 10'd0;
                    w_phase_nxt   = 1'b0;
                    w_pix_cnt_nxt = 11'd0;
                end

                // End of frame; enable only matters here and in IDLE
                if (w_vsync_rise) begin
                    w_frame_done_nxt  = 1'b1;
                    w_frame_count_nxt = frameCount + 8'd1;
                    w_state_nxt       = enable ? S_WAIT_FRAME : S_IDLE;
                end
            end

            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // Datapath and output registers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_x             <= 10'd0;
            r_y             <= 9'd0;
            r_phase         <= 1'b0;
            r_hi            <= 8'd0;
            r_pix_cnt       <= 11'd0;
            r_frame_started <= 1'b0;
            outX            <= 10'd0;
            outY            <= 9'd0;
            pixelValue      <= 16'd0;
            pixelValid      <= 1'b0;
            frameStart      <= 1'b0;
            frameDone       <= 1'b0;
            lineErr         <= 1'b0;
            frameCount      <= 8'd0;
        end else begin
            r_x             <= w_x_nxt;
            r_y             <= w_y_nxt;
            r_phase         <= w_phase_nxt;
            r_hi            <= w_hi_nxt;
            r_pix_cnt       <= w_pix_cnt_nxt;
            r_frame_started <= w_frame_started_nxt;
            outX            <= w_out_x_nxt;
            outY            <= w_out_y_nxt;
            pixelValue      <= w_pixel_value_nxt;
            pixelValid      <= w_pixel_valid_nxt;
            frameStart      <= w_frame_start_nxt;
            frameDone       <= w_frame_done_nxt;
            lineErr         <= w_line_err_nxt;
            frameCount      <= w_frame_count_nxt;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_ov7670_pixel_capture.sv
`default_nettype none
// ============================================================================
// Module      : tb_ov7670_pixel_capture
// Description : Self-checking bench for ov7670_pixel_capture with a small
//               line/frame reference model (H_ACTIVE=4, V_ACTIVE=2).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ov7670_pixel_capture;

    localparam int H = 4;
    localparam int V = 2;

    logic        clk = 1'b0;
    logic        reset;
    logic        pclk_in;
    logic        href_in;
    logic        vsync_in;
    logic [7:0]  data_in;
    logic        enable;
    logic [9:0]  outX;
    logic [8:0]  outY;
    logic [15:0] pixelValue;
    logic        pixelValid;
    logic        frameStart;
    logic        frameDone;
    logic        lineErr;
    logic [7:0]  frameCount;

    ov7670_pixel_capture #(
        .H_ACTIVE   (H),
        .V_ACTIVE   (V),
        .SYNC_STAGES(2)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .pclk_in   (pclk_in),
        .href_in   (href_in),
        .vsync_in  (vsync_in),
        .data_in   (data_in),
        .enable    (enable),
        .outX      (outX),
        .outY      (outY),
        .pixelValue(pixelValue),
        .pixelValid(pixelValid),
        .frameStart(frameStart),
        .frameDone (frameDone),
        .lineErr   (lineErr),
        .frameCount(frameCount)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          x;
        int          y;
        logic [15:0] v;
        longint      cyc;
    } exp_t;

    exp_t   exp_q[$];
    int     tests = 0;
    int     fails = 0;
    longint cyc = 0;
    bit     mon_en = 0;
    bit     fs_pending = 0;
    int     cnt_fs = 0, cnt_fd = 0, cnt_le = 0;
    int     exp_fs = 0, exp_fd = 0, exp_le = 0, exp_fc = 0;
    logic   prev_pv = 0, prev_fs = 0, prev_fd = 0, prev_le = 0;
    logic [7:0] pat = 8'h12;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        tests++;
        assert (obs === expv) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // Output monitor: pixels against the expected queue, pulse counting
    always @(negedge clk) begin
        if (mon_en) begin
            if (pixelValid === 1'b1) begin
                check("pv_width", {63'd0, prev_pv}, 64'd0);
                if (exp_q.size() == 0) begin
                    check("unexpected_pixel", {63'd0, pixelValid}, 64'd0);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    check("pix_x",   64'(outX), 64'(e.x));
                    check("pix_y",   64'(outY), 64'(e.y));
                    check("pix_val", 64'(pixelValue), 64'(e.v));
                    check("pix_latency", 64'(cyc), 64'(e.cyc));
                end
            end
            if (frameStart === 1'b1) begin
                cnt_fs++;
                check("fs_width", {63'd0, prev_fs}, 64'd0);
            end
            if (frameDone === 1'b1) begin
                cnt_fd++;
                check("fd_width", {63'd0, prev_fd}, 64'd0);
            end
            if (lineErr === 1'b1) begin
                cnt_le++;
                check("le_width", {63'd0, prev_le}, 64'd0);
            end
            prev_pv = pixelValid;
            prev_fs = frameStart;
            prev_fd = frameDone;
            prev_le = lineErr;
        end
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    // One camera byte: data/pclk low for 2 clk, pclk high for 2 clk
    task automatic send_byte(input logic [7:0] b, output longint c_rise);
        data_in = b;
        pclk_in = 1'b0;
        href_in = 1'b1;
        tick(2);
        pclk_in = 1'b1;
        c_rise  = cyc;
        tick(2);
    endtask

    task automatic check_zero_outputs(input string tag);
        check(tag, {17'd0, outX, outY, pixelValue, pixelValid, frameStart,
                    frameDone, lineErr, frameCount}, 64'd0);
    endtask

    task automatic do_reset();
        tick(4);
        reset = 1'b0;
        #1;
        check_zero_outputs("async_reset_outputs");
        exp_fc = 0;
        repeat (3) @(negedge clk);
        reset = 1'b1;
    endtask

    // One line of nbytes; reference model: pixel p = bytes 2p,2p+1, kept
    // only if p<H and line<V; line error whenever nbytes != 2*H.
    task automatic send_line(input int nbytes, input int line, input bit cap_in,
                             input bit rnd, input int rst_at);
        bit         cap;
        logic [7:0] b;
        logic [7:0] hi;
        longint     c;
        cap = cap_in;
        hi  = 8'd0;
        if (cap && fs_pending && nbytes > 0) begin
            exp_fs++;
            fs_pending = 0;
        end
        for (int i = 0; i < nbytes; i++) begin
            if (rnd) begin
                b = 8'($urandom);
            end else begin
                b   = pat;
                pat = pat + 8'h22;
            end
            send_byte(b, c);
            if ((i % 2 == 1) && cap && (i / 2 < H) && (line < V)) begin
                exp_q.push_back('{i / 2, line, {hi, b}, c + 3});
            end
            hi = b;
            if (i == rst_at - 1) begin
                do_reset();
                cap = 0;
            end
        end
        pclk_in = 1'b0;
        href_in = 1'b0;
        if (cap && nbytes != 2 * H) exp_le++;
        tick($urandom_range(6, 12));
    endtask

    task automatic frame_begin();
        vsync_in = 1'b1;
        tick(8);
        vsync_in = 1'b0;
        fs_pending = 1;
        tick(8);
    endtask

    task automatic step_check(input string tag);
        check({tag, "_frameCount"}, 64'(frameCount), 64'(exp_fc));
        check({tag, "_frameStart_n"}, 64'(cnt_fs), 64'(exp_fs));
        check({tag, "_frameDone_n"}, 64'(cnt_fd), 64'(exp_fd));
        check({tag, "_lineErr_n"}, 64'(cnt_le), 64'(exp_le));
        check({tag, "_pixels_missing"}, 64'(exp_q.size()), 64'd0);
    endtask

    task automatic frame_end(input bit cap, input string tag);
        tick(8);
        vsync_in = 1'b1;
        if (cap) begin
            exp_fd++;
            exp_fc = (exp_fc + 1) % 256;
        end
        tick(16);
        step_check(tag);
    endtask

    initial begin
        reset    = 1'b1;
        pclk_in  = 1'b0;
        href_in  = 1'b0;
        vsync_in = 1'b0;
        data_in  = 8'd0;
        enable   = 1'b1;
        #2 reset = 1'b0;

        // Step 1: reset for 5 clk, then idle bus for 200 clk
        tick(5);
        check_zero_outputs("reset_outputs");
        mon_en = 1;
        reset  = 1'b1;
        tick(200);
        check_zero_outputs("idle_outputs");
        step_check("idle");

        // Step 2: two full lines with the incrementing byte pattern
        frame_begin();
        send_line(8, 0, 1, 0, 0);
        send_line(8, 1, 1, 0, 0);
        frame_end(1, "full_frame");

        // Step 3: short line (3 pixels) then a full line
        frame_begin();
        send_line(6, 0, 1, 1, 0);
        send_line(8, 1, 1, 1, 0);
        frame_end(1, "short_line");

        // Step 4: long line, odd byte count, then an out-of-range line
        frame_begin();
        send_line(12, 0, 1, 1, 0);
        send_line(7, 1, 1, 1, 0);
        send_line(8, 2, 1, 1, 0);
        frame_end(1, "long_odd_lines");

        // Step 5: enable dropped mid-frame; frame completes, next is ignored
        frame_begin();
        send_line(8, 0, 1, 1, 0);
        enable = 1'b0;
        send_line(8, 1, 1, 1, 0);
        frame_end(1, "enable_drop");
        frame_begin();
        send_line(8, 0, 0, 1, 0);
        send_line(8, 1, 0, 1, 0);
        enable = 1'b1;
        frame_end(0, "disabled_frame");
        frame_begin();
        send_line(8, 0, 1, 1, 0);
        send_line(8, 1, 1, 1, 0);
        frame_end(1, "reenabled");

        // Step 6: async reset mid-line at x=2, then recovery
        frame_begin();
        send_line(8, 0, 1, 1, 4);
        send_line(8, 1, 0, 1, 0);
        frame_end(0, "after_reset");
        frame_begin();
        send_line(8, 0, 1, 1, 0);
        send_line(8, 1, 1, 1, 0);
        frame_end(1, "recovered");

        tick(10);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/ov7670_pixel_capture.md
Name: ov7670_pixel_capture

Overview:
- Upstream capture stage feeding frameBuffer_greyScale. Sits between the OV7670 parallel bus and the frame buffer.
- Oversamples the camera PCLK/HREF/VSYNC in the single system clock domain (clkMain, 100 MHz).
- Pairs byte-serial RGB565 into 16-bit pixels and emits X/Y coordinates with a one-cycle pixelValid strobe.
- Also reports frame boundaries and line-length errors.

Parameters:
- H_ACTIVE, 640, pixels per line accepted.
- V_ACTIVE, 480, lines per frame accepted.
- SYNC_STAGES, 2, synchroniser depth for pclk/href/vsync/data (minimum 2).

Ports:
- clk  in  1  system clock; pclk_in must be ≤ clk/4.
- reset  in  1  asynchronous, active-low reset.
- pclk_in  in  1  camera pixel clock, sampled as data.
- href_in  in  1  camera line-valid.
- vsync_in  in  1  camera frame sync, high between frames.
- data_in  in  8  camera data byte.
- enable  in  1  capture enable.
- outX  out  10  column of current pixel.
- outY  out  9  row of current pixel.
- pixelValue  out  16  RGB565 pixel, first byte in [15:8].
- pixelValid  out  1  one-cycle strobe; outX/outY/pixelValue valid while high.
- frameStart  out  1  one-cycle pulse at first active line of a frame.
- frameDone  out  1  one-cycle pulse at end of frame.
- lineErr  out  1  one-cycle pulse when a line ends with a pixel count other than H_ACTIVE.
- frameCount  out  8  completed frames, wraps 255→0.

Behaviour:
- Reset (reset=0, async): all outputs 0, state IDLE, byte phase 0, x=y=0, synchroniser flops 0.
- Synchronisers:
  - pclk/href/vsync pass through SYNC_STAGES flops.
  - data_in passes through the same depth so it stays aligned with pclk.
  - pclkRise = sync_pclk & ~prev_pclk. hrefFall and vsyncRise/Fall are detected the same way.
- State machine:
  - IDLE: wait for vsyncRise with enable=1, then go to WAIT_FRAME.
  - WAIT_FRAME: on vsyncFall, go to ACTIVE and clear x, y, phase. frameStart pulses on the first pclkRise with href=1 in the frame.
  - ACTIVE, on pclkRise with href=1:
    - phase 0: latch high byte, phase←1.
    - phase 1: if x<H_ACTIVE and y<V_ACTIVE, register pixelValue={hi,data}, outX=x, outY=y, and pulse pixelValid for exactly one cycle; then x←min(x+1,H_ACTIVE). phase←0 in all cases.
  - ACTIVE, on hrefFall:
    - If x≠H_ACTIVE, pulse lineErr (counts pixels presented, including dropped ones; track them with a separate 11-bit count).
    - y←y+1, saturating at V_ACTIVE. x←0, phase←0.
    - A half pixel (phase=1) at hrefFall is discarded and also pulses lineErr.
  - ACTIVE, on vsyncRise: pulse frameDone, frameCount←frameCount+1. Go to WAIT_FRAME if enable=1, else IDLE.
- Latency: pixelValid rises exactly 1 clk after the cycle in which the second byte's pclkRise is detected.
- Outputs: outX/outY/pixelValue hold their value between strobes. Pulses never last more than 1 cycle.
- enable deasserted mid-frame: the current frame completes normally, then the block enters IDLE. enable is sampled only at vsyncRise.
- Out-of-range data: pixels with x≥H_ACTIVE or lines with y≥V_ACTIVE produce no pixelValid.
- Simultaneous hrefFall and vsyncRise: apply line handling first, then frame end, both in the same cycle.
- Async reset mid-frame: block returns to IDLE and waits for a new vsyncRise. No partial frameDone.

Test Plan:
- Reset low 5 clk, release with bus idle -> all outputs 0, no strobes for 200 clk.
- H_ACTIVE=4, V_ACTIVE=2, pclk=clk/4, two lines of bytes 0x12,0x34,0x56,0x78,… -> pixelValid ×8; first pixel (0,0)=0x1234, second (1,0)=0x5678; frameStart ×1; frameDone ×1; frameCount=1; lineErr never.
- Line of 3 pixels (H_ACTIVE=4) -> 3 strobes, lineErr pulse at hrefFall, next line starts at x=0, y=1.
- Line of 6 pixels -> strobes at x=0..3 only, lineErr pulse; 7 bytes (odd count) -> lineErr and the half pixel dropped.
- enable→0 mid-frame -> frame completes with frameDone and frameCount increments; following frame yields no strobes; enable→1 then next vsyncRise resumes capture.
- Assert reset mid-line at x=2 -> outputs 0 immediately (async); no strobes until the next vsync high→low sequence; frameCount stays 0.
